// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and types for the two-port bram32 arbiter.
package bram_port_arbiter_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned NPORTS         = 2;

    localparam int unsigned ARB_PRIO_RR    = 0;
    localparam int unsigned ARB_PRIO_FIXED = 1;

    // Which port wins the next two-way tie in round-robin mode.
    typedef enum logic {
        RR_PORT0 = 1'b0,
        RR_PORT1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic with a round-robin pointer; mode_i=1 makes port 0 win every tie.
module rr_arbiter2
    import bram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible_i,
    input  logic       mode_i,
    output logic [1:0] grant_c_o
);

    rr_ptr_e ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= RR_PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer moves to the loser of each grant so the other port wins the next tie.
    always_comb begin
        grant_c_o = 2'b00;
        ptr_d     = ptr_q;
        case (eligible_i)
            2'b01:   grant_c_o = 2'b01;
            2'b10:   grant_c_o = 2'b10;
            2'b11:   grant_c_o = (mode_i || (ptr_q == RR_PORT0)) ? 2'b01 : 2'b10;
            default: grant_c_o = 2'b00;
        endcase
        if (grant_c_o[0]) begin
            ptr_d = RR_PORT1;
        end else if (grant_c_o[1]) begin
            ptr_d = RR_PORT0;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the single-access bram32 between the core LSU (port 0) and the loader/debug master (port 1).
// One access per cycle, one outstanding registered response per port.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_W    = DATA_WIDTH,
    parameter int unsigned PRIO_MODE = ARB_PRIO_RR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    input  logic [1:0][BE_W-1:0]   req_be,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [1:0][DATA_W-1:0] rsp_rdata,
    output logic [1:0]             rsp_is_wr,
    output logic [ADDR_W-1:0]      mem_w_addr,
    output logic [DATA_W-1:0]      mem_w_dat,
    output logic                   mem_w_enb,
    output logic [BE_W-1:0]        mem_byte_enb,
    output logic [ADDR_W-1:0]      mem_r_addr,
    output logic                   mem_r_enb,
    input  logic [DATA_W-1:0]      mem_r_dat
);

    logic [1:0]             eligible;
    logic [1:0]             grant;
    logic                   sel;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [1:0]             rsp_is_wr_q, rsp_is_wr_d;
    logic [1:0][DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // A port with a response still pending cannot issue; reset blocks all issue.
    assign eligible = rst ? 2'b00 : (req_valid & ~rsp_valid_q);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .eligible_i(eligible),
        .mode_i    (PRIO_MODE == ARB_PRIO_FIXED),
        .grant_c_o (grant)
    );

    assign req_ready = grant;
    assign sel       = grant[1];

    // Memory port mux: at most one of the two enables is raised per cycle.
    always_comb begin
        mem_w_addr   = '0;
        mem_w_dat    = '0;
        mem_w_enb    = 1'b0;
        mem_byte_enb = '0;
        mem_r_addr   = '0;
        mem_r_enb    = 1'b0;
        if (|grant) begin
            if (req_we[sel]) begin
                mem_w_enb    = |req_be[sel];
                mem_w_addr   = req_addr[sel];
                mem_w_dat    = req_wdata[sel];
                mem_byte_enb = req_be[sel];
            end else begin
                mem_r_enb  = 1'b1;
                mem_r_addr = req_addr[sel];
            end
        end
    end

    // Response capture on grant, release on consume; grant and consume never coincide per port.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_is_wr_d = rsp_is_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        for (int p = 0; p < NPORTS; p++) begin
            if (grant[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_is_wr_d[p] = req_we[p];
                rsp_rdata_d[p] = req_we[p] ? '0 : mem_r_dat;
            end else if (rsp_ready[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_is_wr_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_is_wr_q <= rsp_is_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_is_wr = rsp_is_wr_q;
    assign rsp_rdata = rsp_rdata_q;

    mem_enb_exclusive_a: assert property (@(posedge clk) !(mem_w_enb && mem_r_enb));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: round-robin and fixed-priority instances,
// a behavioural bram32, and a reference memory feeding a response scoreboard.
module tb_bram_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid, req_we, rsp_ready;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][DW-1:0]  req_wdata;
    logic [1:0][3:0]     req_be;

    logic [1:0]          req_ready, rsp_valid, rsp_is_wr;
    logic [1:0][DW-1:0]  rsp_rdata;
    logic [AW-1:0]       mem_w_addr, mem_r_addr;
    logic [DW-1:0]       mem_w_dat, mem_r_dat;
    logic                mem_w_enb, mem_r_enb;
    logic [3:0]          mem_byte_enb;

    logic [1:0]          fx_req_ready, fx_rsp_valid, fx_rsp_is_wr;
    logic [1:0][DW-1:0]  fx_rsp_rdata;
    logic [AW-1:0]       fx_mem_w_addr, fx_mem_r_addr;
    logic [DW-1:0]       fx_mem_w_dat, fx_mem_r_dat;
    logic                fx_mem_w_enb, fx_mem_r_enb;
    logic [3:0]          fx_mem_byte_enb;

    logic [31:0]         tb_mem  [0:1023];
    logic [31:0]         ref_mem [0:1023];
    logic                bd_we;
    logic [9:0]          bd_idx;
    logic [31:0]         bd_data;
    logic [32:0]         exp_q0[$];
    logic [32:0]         exp_q1[$];
    int                  n_asserts = 0;
    int                  n_fail    = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.PRIO_MODE(0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_is_wr(rsp_is_wr),
        .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
        .mem_byte_enb(mem_byte_enb), .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb),
        .mem_r_dat(mem_r_dat)
    );

    bram_port_arbiter #(.PRIO_MODE(1)) u_fx (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(fx_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(fx_rsp_rdata), .rsp_is_wr(fx_rsp_is_wr),
        .mem_w_addr(fx_mem_w_addr), .mem_w_dat(fx_mem_w_dat), .mem_w_enb(fx_mem_w_enb),
        .mem_byte_enb(fx_mem_byte_enb), .mem_r_addr(fx_mem_r_addr), .mem_r_enb(fx_mem_r_enb),
        .mem_r_dat(fx_mem_r_dat)
    );

    // Behavioural bram32: combinational read, byte-enabled write, plus a backdoor preload.
    assign mem_r_dat    = tb_mem[mem_r_addr[11:2]];
    assign fx_mem_r_dat = tb_mem[fx_mem_r_addr[11:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            tb_mem[bd_idx] <= bd_data;
        end else if (mem_w_enb) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enb[b]) tb_mem[mem_w_addr[11:2]][8*b +: 8] <= mem_w_dat[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_idx  = a[11:2];
        bd_data = d;
        ref_mem[a[11:2]] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [11:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_be[p]    = be;
    endtask

    // Scoreboard: compare consumed responses, then push expectations for accepted requests.
    task automatic monitor();
        logic [32:0] e;
        chk("enb_exclusive", {mem_w_enb & mem_r_enb, fx_mem_w_enb & fx_mem_r_enb}, 64'd0);
        for (int p = 0; p < 2; p++) begin
            if (rsp_valid[p] && rsp_ready[p]) begin
                if (p == 0) begin
                    chk("sb_p0_nonempty", 64'(exp_q0.size() != 0), 64'd1);
                    if (exp_q0.size() != 0) begin
                        e = exp_q0.pop_front();
                        chk("sb_p0_rsp", {rsp_is_wr[0], rsp_rdata[0]}, 64'(e));
                    end
                end else begin
                    chk("sb_p1_nonempty", 64'(exp_q1.size() != 0), 64'd1);
                    if (exp_q1.size() != 0) begin
                        e = exp_q1.pop_front();
                        chk("sb_p1_rsp", {rsp_is_wr[1], rsp_rdata[1]}, 64'(e));
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (req_valid[p] && req_ready[p]) begin
                if (req_we[p]) begin
                    e = {1'b1, 32'h0};
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[p][b]) ref_mem[req_addr[p][11:2]][8*b +: 8] = req_wdata[p][8*b +: 8];
                    end
                end else begin
                    e = {1'b0, ref_mem[req_addr[p][11:2]]};
                end
                if (p == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
        end
    endtask

    task automatic step();
        #1;
        monitor();
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) begin
            step();
            nxt();
        end
    endtask

    initial begin
        logic [1:0] eg;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 2'b11;
        bd_we     = 1'b0;
        bd_idx    = '0;
        bd_data   = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        @(negedge clk);
        preload(12'h010, 32'hDEADBEEF);
        preload(12'h020, 32'hAAAAAAAA);
        preload(12'h040, 32'h00000000);
        preload(12'h080, 32'h55555555);

        // Reset state, with requests present while rst is high
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        set_req(1, 1'b1, 12'h020, 32'h1, 4'hF);
        step();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_r_enb", mem_r_enb, 1'b0);
        chk("rst_w_enb", mem_w_enb, 1'b0);
        chk("rst_w_addr", mem_w_addr, 12'h0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_rsp_is_wr", rsp_is_wr, 2'b00);
        nxt();
        rst = 1'b0;
        idle(1);

        // Single read
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        chk("rd_ready", req_ready, 2'b01);
        chk("rd_r_enb", mem_r_enb, 1'b1);
        chk("rd_r_addr", mem_r_addr, 12'h010);
        chk("rd_w_enb", mem_w_enb, 1'b0);
        chk("rd_rsp_not_yet", rsp_valid, 2'b00);
        nxt();
        req_valid = 2'b00;
        step();
        chk("rd_rsp_valid", rsp_valid, 2'b01);
        chk("rd_rdata", rsp_rdata[0], 32'hDEADBEEF);
        chk("rd_is_wr", rsp_is_wr[0], 1'b0);
        nxt();

        // Byte write, then a be=0000 write that must not touch memory
        set_req(1, 1'b1, 12'h020, 32'h11223344, 4'b0010);
        step();
        chk("bw_ready", req_ready, 2'b10);
        chk("bw_w_enb", mem_w_enb, 1'b1);
        chk("bw_be", mem_byte_enb, 4'b0010);
        chk("bw_w_addr", mem_w_addr, 12'h020);
        chk("bw_w_dat", mem_w_dat, 32'h11223344);
        chk("bw_r_enb", mem_r_enb, 1'b0);
        nxt();
        req_valid = 2'b00;
        step();
        chk("bw_ack_valid", rsp_valid, 2'b10);
        chk("bw_ack_is_wr", rsp_is_wr[1], 1'b1);
        chk("bw_ack_rdata", rsp_rdata[1], 32'h0);
        chk("bw_mem", tb_mem[8], 32'hAAAA33AA);
        nxt();
        set_req(1, 1'b1, 12'h020, 32'hFFFFFFFF, 4'b0000);
        step();
        chk("be0_ready", req_ready, 2'b10);
        chk("be0_w_enb", mem_w_enb, 1'b0);
        chk("be0_r_enb", mem_r_enb, 1'b0);
        nxt();
        req_valid = 2'b00;
        step();
        chk("be0_ack", rsp_is_wr, 2'b10);
        chk("be0_mem", tb_mem[8], 32'hAAAA33AA);
        nxt();

        // Contention: both read every cycle; both modes alternate here
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        set_req(1, 1'b0, 12'h020, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
            chk("rr_gnt", req_ready, eg);
            chk("fx_gnt", fx_req_ready, eg);
            nxt();
        end
        idle(2);

        // Pointer at port 1 after a lone port 0 grant: modes now disagree on a tie
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        chk("tie_pre_gnt", req_ready, 2'b01);
        nxt();
        idle(1);
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        set_req(1, 1'b0, 12'h020, 32'h0, 4'h0);
        step();
        chk("tie_rr_gnt", req_ready, 2'b10);
        chk("tie_fx_gnt", fx_req_ready, 2'b01);
        nxt();
        req_valid = 2'b00;
        step();
        chk("tie_rr_rsp", rsp_valid, 2'b10);
        chk("tie_fx_rsp", fx_rsp_valid, 2'b01);
        chk("tie_fx_rdata", fx_rsp_rdata[0], 32'hDEADBEEF);
        nxt();
        idle(1);

        // Backpressure on port 0 while port 1 keeps being served
        rsp_ready = 2'b10;
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        chk("bp_first_gnt", req_ready, 2'b01);
        nxt();
        set_req(0, 1'b0, 12'h020, 32'h0, 4'h0);
        set_req(1, 1'b0, 12'h010, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            eg = (i % 2 == 0) ? 2'b10 : 2'b00;
            step();
            chk("bp_valid", rsp_valid[0], 1'b1);
            chk("bp_rdata", rsp_rdata[0], 32'hDEADBEEF);
            chk("bp_gnt", req_ready, eg);
            nxt();
        end
        rsp_ready = 2'b11;
        req_valid = 2'b00;
        step();
        chk("bp_release", rsp_valid, 2'b11);
        nxt();
        step();
        chk("bp_drained", rsp_valid, 2'b00);
        nxt();

        // Write on port 1 then read of the same word on port 0
        set_req(1, 1'b1, 12'h040, 32'h12345678, 4'hF);
        step();
        chk("wtr_wr_gnt", req_ready, 2'b10);
        nxt();
        req_valid[1] = 1'b0;
        set_req(0, 1'b0, 12'h040, 32'h0, 4'h0);
        step();
        chk("wtr_rd_gnt", req_ready, 2'b01);
        chk("wtr_r_addr", mem_r_addr, 12'h040);
        nxt();
        req_valid = 2'b00;
        step();
        chk("wtr_rdata", rsp_rdata[0], 32'h12345678);
        nxt();

        // Reset with a response pending and a write presented during reset
        rsp_ready = 2'b10;
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        chk("rm_accept", req_ready, 2'b01);
        nxt();
        req_valid = 2'b00;
        step();
        chk("rm_pending", rsp_valid, 2'b01);
        nxt();
        rst = 1'b1;
        set_req(1, 1'b1, 12'h080, 32'h0, 4'hF);
        step();
        chk("rm_ready", req_ready, 2'b00);
        chk("rm_w_enb", mem_w_enb, 1'b0);
        chk("rm_r_enb", mem_r_enb, 1'b0);
        exp_q0.delete();
        exp_q1.delete();
        nxt();
        rst       = 1'b0;
        rsp_ready = 2'b11;
        set_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
        set_req(1, 1'b0, 12'h080, 32'h0, 4'h0);
        step();
        chk("rm_rsp_valid", rsp_valid, 2'b00);
        chk("rm_rsp_rdata", rsp_rdata, 64'h0);
        chk("rm_rsp_is_wr", rsp_is_wr, 2'b00);
        chk("rm_ptr_gnt", req_ready, 2'b01);
        nxt();
        step();
        chk("rm_gnt2", req_ready, 2'b10);
        nxt();
        idle(2);
        chk("rm_mem", tb_mem[32], 32'h55555555);
        chk("sb_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
